// File: rtl/cfu_wb_dot_pkg.sv
// Shared opcodes, FSM states and constants for the cfu_wb_dot dot-product CFU.
package cfu_wb_dot_pkg;

  typedef enum logic [2:0] {
    OP_SET_LEN    = 3'd0,
    OP_DOT        = 3'd1,
    OP_SET_OFFSET = 3'd2,
    OP_STATUS     = 3'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StMac,
    StResp
  } state_e;

  localparam logic [31:0] ERR_RESULT = 32'h8000_0000;

endpackage

// File: rtl/cfu_lane_mac.sv
// Combinational signed packed-lane multiply and adder tree.
// Each A lane is offset before the multiply; pass zero to get a plain dot product.
module cfu_lane_mac #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 32
) (
  input  logic [31:0]               a,
  input  logic [31:0]               b,
  input  logic signed [32/LANES:0]  offset,
  output logic [ACC_W-1:0]          sum
);

  localparam int unsigned W = 32 / LANES;

  logic signed [ACC_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // W+2 bits hold sext(lane) + a (W+1)-bit offset without overflow.
    logic signed [W+1:0]   av;
    logic signed [W+1:0]   bv;
    logic signed [2*W+1:0] p;
    assign av = (W+2)'(signed'(a[i*W +: W])) + (W+2)'(offset);
    assign bv = (W+2)'(signed'(b[i*W +: W]));
    assign p  = (2*W+2)'(av) * (2*W+2)'(bv);
    assign prod[i] = ACC_W'(p);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + prod[i];
    end
  end

endmodule

// File: rtl/cfu_wb_dot.sv
// CFU that fetches LEN word pairs over Wishbone and returns their packed-lane dot product.
// Define CFU_DOT_INPUT_OFFSET_EN to add the SET_OFFSET opcode and per-lane A offset.
module cfu_wb_dot
  import cfu_wb_dot_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned ACC_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [29:0] cfu_ram_adr,
  output logic [31:0] cfu_ram_dat_mosi,
  output logic [3:0]  cfu_ram_sel,
  output logic        cfu_ram_cyc,
  output logic        cfu_ram_stb,
  output logic        cfu_ram_we,
  output logic [2:0]  cfu_ram_cti,
  output logic [1:0]  cfu_ram_bte,
  input  logic [31:0] cfu_ram_dat_miso,
  input  logic        cfu_ram_ack,
  input  logic        cfu_ram_err
);

  localparam int unsigned W  = 32 / LANES;
  localparam int unsigned LW = $clog2(MAX_LEN) + 1;
  localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);

  state_e           state;
  logic [LW-1:0]    len;
  logic [LW-1:0]    cnt;
  logic [29:0]      ptr_a;
  logic [29:0]      ptr_b;
  logic [31:0]      word_a;
  logic [31:0]      word_b;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] lane_sum;
  logic             err_sticky;
  logic [LW-1:0]    len_sat;
  logic [31:0]      result;
  logic signed [W:0] offset;
  logic             unused;

  assign cfu_ram_dat_mosi = '0;
  assign cfu_ram_sel      = 4'b1111;
  assign cfu_ram_we       = 1'b0;
  assign cfu_ram_cti      = '0;
  assign cfu_ram_bte      = '0;

  assign cmd_ready = (state == StIdle) && !rsp_valid;
  assign len_sat   = (cmd_payload_inputs_0 > MAX_LEN_W) ? MAX_LEN_W[LW-1:0]
                                                        : cmd_payload_inputs_0[LW-1:0];
  assign result    = 32'(signed'(acc));
  assign unused    = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[1:0]};

  cfu_lane_mac #(
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_lane_mac (
    .a      (word_a),
    .b      (word_b),
    .offset (offset),
    .sum    (lane_sum)
  );

`ifdef CFU_DOT_INPUT_OFFSET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset <= '0;
    end else if (cmd_valid && cmd_ready && (cmd_payload_function_id[2:0] == OP_SET_OFFSET)) begin
      offset <= signed'(cmd_payload_inputs_0[W:0]);
    end
  end
`else
  assign offset = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= StIdle;
      len                   <= LW'(1);
      cnt                   <= '0;
      ptr_a                 <= '0;
      ptr_b                 <= '0;
      word_a                <= '0;
      word_b                <= '0;
      acc                   <= '0;
      err_sticky            <= 1'b0;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      cfu_ram_adr           <= '0;
      cfu_ram_cyc           <= 1'b0;
      cfu_ram_stb           <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            case (cmd_payload_function_id[2:0])
              OP_SET_LEN: begin
                len                   <= len_sat;
                rsp_valid             <= 1'b1;
                rsp_payload_outputs_0 <= 32'(len_sat);
              end
              OP_DOT: begin
                ptr_a <= cmd_payload_inputs_0[31:2];
                ptr_b <= cmd_payload_inputs_1[31:2];
                cnt   <= len;
                acc   <= '0;
                if (len == '0) begin
                  state <= StResp;
                end else begin
                  state       <= StRdA;
                  cfu_ram_adr <= cmd_payload_inputs_0[31:2];
                  cfu_ram_cyc <= 1'b1;
                  cfu_ram_stb <= 1'b1;
                end
              end
              OP_STATUS: begin
                rsp_valid             <= 1'b1;
                rsp_payload_outputs_0 <= {31'b0, err_sticky};
                err_sticky            <= 1'b0;
              end
              default: begin
                rsp_valid             <= 1'b1;
                rsp_payload_outputs_0 <= '0;
              end
            endcase
          end
        end
        StRdA, StRdB: begin
          // err takes priority over a simultaneous ack.
          if (cfu_ram_err) begin
            err_sticky            <= 1'b1;
            cfu_ram_cyc           <= 1'b0;
            cfu_ram_stb           <= 1'b0;
            rsp_valid             <= 1'b1;
            rsp_payload_outputs_0 <= ERR_RESULT;
            state                 <= StIdle;
          end else if (cfu_ram_ack) begin
            if (state == StRdA) begin
              word_a      <= cfu_ram_dat_miso;
              cfu_ram_adr <= ptr_b;
              state       <= StRdB;
            end else begin
              word_b      <= cfu_ram_dat_miso;
              cfu_ram_cyc <= 1'b0;
              cfu_ram_stb <= 1'b0;
              state       <= StMac;
            end
          end
        end
        StMac: begin
          acc   <= acc + lane_sum;
          ptr_a <= ptr_a + 30'd1;
          ptr_b <= ptr_b + 30'd1;
          cnt   <= cnt - LW'(1);
          if (cnt != LW'(1)) begin
            cfu_ram_adr <= ptr_a + 30'd1;
            cfu_ram_cyc <= 1'b1;
            cfu_ram_stb <= 1'b1;
            state       <= StRdA;
          end else begin
            state <= StResp;
          end
        end
        StResp: begin
          rsp_valid             <= 1'b1;
          rsp_payload_outputs_0 <= result;
          state                 <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_wb_dot.sv
// Scoreboard bench for cfu_wb_dot: directed commands push expected responses, a monitor checks them.
module tb_cfu_wb_dot;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [29:0] adr;
  logic [31:0] dat_mosi;
  logic [3:0]  sel;
  logic        cyc, stb, we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_miso = '0;
  logic        ack = 1'b0;
  logic        err = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [29:0] adr_log[$];
  int cyc_cnt = 0;
  int rd_idx = 0;
  int err_idx = -1;
  int waits = 0;
  int wcnt = 0;
  logic [31:0] mem [256];
  logic        pend = 1'b0;
  logic [29:0] prev_adr = '0;

  always #5 clk = ~clk;

  cfu_wb_dot dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data),
    .cfu_ram_adr             (adr),
    .cfu_ram_dat_mosi        (dat_mosi),
    .cfu_ram_sel             (sel),
    .cfu_ram_cyc             (cyc),
    .cfu_ram_stb             (stb),
    .cfu_ram_we              (we),
    .cfu_ram_cti             (cti),
    .cfu_ram_bte             (bte),
    .cfu_ram_dat_miso        (dat_miso),
    .cfu_ram_ack             (ack),
    .cfu_ram_err             (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Wishbone slave: ack after `waits` extra cycles (waits=0 -> ack on 2nd stb cycle).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ack  <= 1'b0;
      err  <= 1'b0;
      wcnt <= 0;
    end else if (cyc && stb && !ack && !err) begin
      if (wcnt == waits) begin
        ack      <= 1'b1;
        err      <= (rd_idx == err_idx);
        dat_miso <= mem[adr[7:0]];
        rd_idx   <= rd_idx + 1;
        wcnt     <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack  <= 1'b0;
      err  <= 1'b0;
      wcnt <= 0;
    end
  end

  // Bus monitor: address log, cycle count, adr stability while waiting.
  always @(negedge clk) begin
    if (cyc && stb && pend) check("adr_stable", 32'(adr), 32'(prev_adr));
    pend     = cyc && stb && !ack && !err;
    prev_adr = adr;
    if (cyc && stb && (ack || err)) adr_log.push_back(adr);
    if (cyc) cyc_cnt++;
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", rsp_data, 32'hxxxx_xxxx);
      end else begin
        check("rsp", rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] exp, input bit push);
    int n;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b1;
    fid = {7'd0, op};
    in0 = a0;
    in1 = a1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rsp_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int base;
    int c0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 32'h0102_0304;
    mem[32] = 32'h0506_0708;
    mem[20] = 32'hFFFF_FFFF;
    mem[21] = 32'h8080_8080;
    mem[40] = 32'h0101_0101;
    mem[41] = 32'h7F7F_7F7F;
    mem[50] = 32'h8080_8080;
    mem[51] = 32'h0101_0101;

    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_cyc_stb", 32'({cyc, stb}), 32'd0);
    check("reset_adr", 32'(adr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset len is 1.
    issue(3'd1, 32'd64, 32'd128, 32'd70, 1'b1);
    wait_done();

    issue(3'd0, 32'd5000, 32'd0, 32'd1024, 1'b1);
    issue(3'd0, 32'd2, 32'd0, 32'd2, 1'b1);
    wait_done();

    // len=2 with latency and address-sequence checks.
    base = adr_log.size();
    issue(3'd1, 32'd80, 32'd160, 32'hFFFF_01FC, 1'b1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dot_latency", 32'(n), 32'd11);
    wait_done();
    check("adr_count", 32'(adr_log.size() - base), 32'd4);
    if (adr_log.size() - base == 4) begin
      check("adr_0", 32'(adr_log[base]), 32'd20);
      check("adr_1", 32'(adr_log[base+1]), 32'd40);
      check("adr_2", 32'(adr_log[base+2]), 32'd21);
      check("adr_3", 32'(adr_log[base+3]), 32'd41);
    end

    // ack+err on the 2nd RD_B.
    err_idx = rd_idx + 3;
    issue(3'd1, 32'd80, 32'd160, 32'h8000_0000, 1'b1);
    wait_done();
    err_idx = -1;
    issue(3'd3, 32'd0, 32'd0, 32'd1, 1'b1);
    issue(3'd3, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(3'd5, 32'd7, 32'd0, 32'd0, 1'b1);
    wait_done();

    // len=0: no bus traffic.
    issue(3'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_done();
    c0 = cyc_cnt;
    issue(3'd1, 32'd64, 32'd128, 32'd0, 1'b1);
    wait_done();
    check("len0_no_cyc", 32'(cyc_cnt - c0), 32'd0);

    // Long wait states.
    waits = 3;
    issue(3'd0, 32'd1, 32'd0, 32'd1, 1'b1);
    issue(3'd1, 32'd64, 32'd128, 32'd70, 1'b1);
    wait_done();
    waits = 0;

    // Response backpressure.
    rsp_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd0, 32'd3, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, 32'd3);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_done();

    // Reset during RD_A drops the bus immediately and restores len=1.
    waits = 5;
    issue(3'd1, 32'd64, 32'd128, 32'd0, 1'b0);
    check("rd_a_cyc", 32'({cyc, stb}), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_cyc_stb", 32'({cyc, stb}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waits = 0;
    issue(3'd1, 32'd64, 32'd128, 32'd70, 1'b1);
    wait_done();

    // Opcode 2 and lane offset.
    issue(3'd2, 32'd128, 32'd0, 32'd0, 1'b1);
`ifdef CFU_DOT_INPUT_OFFSET_EN
    issue(3'd1, 32'd200, 32'd204, 32'd0, 1'b1);
`else
    issue(3'd1, 32'd200, 32'd204, 32'hFFFF_FE00, 1'b1);
`endif
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfu_wb_dot.md
Name: cfu_wb_dot

Overview:
- Parametrised successor to the two-word fetch-and-add CFU. Attaches to the CPU CFU command/response port and a Wishbone classic read-only master port.
- Fetches LEN word pairs from two memory vectors and accumulates the signed packed-lane dot product. Returns the 32-bit result to the CPU.
- Used for TFLite conv and fully-connected inner loops.

Parameters:
- LANES, 4, packed signed lanes per 32-bit word; legal values 1/2/4; lane width W = 32/LANES.
- MAX_LEN, 1024, maximum vector length in words; sets the length counter width to $clog2(MAX_LEN)+1.
- ACC_W, 32, accumulator width; result is the low 32 bits, sign-extended if ACC_W < 32.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid & ready
- cmd_payload_function_id  in  10  [2:0] opcode, rest ignored
- cmd_payload_inputs_0  in  32  byte address A / operand
- cmd_payload_inputs_1  in  32  byte address B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU takes response
- rsp_payload_outputs_0  out  32  result
- cfu_ram_adr  out  30  word address
- cfu_ram_dat_mosi  out  32  tied 0
- cfu_ram_sel  out  4  tied 4'b1111
- cfu_ram_cyc, cfu_ram_stb  out  1 each  bus cycle / strobe
- cfu_ram_we  out  1  tied 0
- cfu_ram_cti  out  3  tied 0
- cfu_ram_bte  out  2  tied 0
- cfu_ram_dat_miso  in  32  read data
- cfu_ram_ack, cfu_ram_err  in  1 each  slave termination

Behaviour:
- Reset: reset is asynchronous, active-high. On reset: rsp_valid=0, rsp_payload=0, cyc=stb=0, adr=0, len=1, status=0, state IDLE. Asserting reset mid-transfer drops cyc/stb immediately.
- All logic is posedge clk. cmd_ready = (state==IDLE) & ~rsp_valid.
- Once asserted, rsp_valid and rsp_payload hold until the cycle rsp_ready=1.
- Opcodes:
  - 0 SET_LEN: len <= inputs_0, saturated to MAX_LEN. Response is the stored len, one cycle after accept.
  - 1 DOT: run the dot product over len words (below).
  - 3 STATUS: response {31'b0, err_sticky}; clears err_sticky.
  - Others: response 0 one cycle after accept.
- States: IDLE, RD_A, RD_B, MAC, RESP.
  - IDLE -> RD_A on DOT accept. Latch ptrA=inputs_0[31:2], ptrB=inputs_1[31:2], cnt=len, acc=0.
  - len==0: go directly to RESP with result 0; no bus traffic.
  - RD_A: adr=ptrA, cyc=stb=1. On ack, latch word A and go to RD_B.
  - RD_B: adr=ptrB, cyc=stb=1. On ack, latch word B and go to MAC; cyc=stb=0 during MAC.
  - MAC (one cycle): acc += sum over lanes of sext(A_lane)*sext(B_lane). ptrA++, ptrB++, cnt--. Go to RD_A if cnt!=1, else RESP.
  - RESP: load payload, rsp_valid=1, return to IDLE.
- Arithmetic: lane products are signed W×W -> 2W bits, sign-extended to ACC_W. Accumulation wraps mod 2^ACC_W with no saturation. Pointers wrap mod 2^30.
- Bus error: err in RD_A or RD_B aborts the run. Sets err_sticky, drops cyc/stb, responds 32'h8000_0000. ack and err together: err wins.
- Wait states: any number of cycles before ack. adr/stb stay stable until ack/err.
- Latency with a 1-wait slave (ack on the 2nd stb cycle): 5 cycles per word, plus 1 for RESP.

Optional Feature:
- Macro CFU_DOT_INPUT_OFFSET_EN.
- Defined:
  - Opcode 2 SET_OFFSET stores signed (W+1)-bit offset = inputs_0[W:0]; reset value 0. Response 0.
  - During MAC each A lane becomes sext(A_lane)+offset before the multiply; product width grows to 2W+1.
- Undefined: opcode 2 is treated as unknown (response 0); no offset register exists.

Decomposition:
- Package cfu_wb_dot_pkg:
  - opcode enum (OP_SET_LEN=0, OP_DOT=1, OP_SET_OFFSET=2, OP_STATUS=3)
  - state enum
  - ERR_RESULT=32'h8000_0000
- Sub-module cfu_lane_mac: combinational lane multiply and adder tree, parametrised by LANES and ACC_W, with an optional offset input.

Test Plan:
- SET_LEN 0 then DOT: no cyc ever asserted; rsp=0. SET_LEN 5000 returns 1024.
- LANES=4, len=1, A=0x01020304, B=0x05060708 -> rsp 70 (0x46).
- len=2, A words {0xFFFFFFFF, 0x80808080}, B words {0x01010101, 0x7F7F7F7F} -> -4 + 4*(-128*127) = -65028 (0xFFFF01FC). Adr sequence A, B, A+1, B+1.
- Slave asserts err on the 2nd RD_B -> rsp 0x80000000; next STATUS=1, following STATUS=0.
- rsp_ready held low 10 cycles -> rsp_valid/payload stable, cmd_ready=0. Reset asserted mid-RD_A -> cyc/stb low in the same cycle.
- With CFU_DOT_INPUT_OFFSET_EN: SET_OFFSET 128, A=0x80808080, B=0x01010101, len=1 -> rsp 0.
